// File: rtl/bus_seven_seg_scan_ctrl.sv
// rtl/bus_seven_seg_scan_ctrl.sv - bus-mapped multi-digit seven-segment scan controller
module bus_seven_seg_scan_ctrl #(
    parameter logic [7:0] IO_ADDRESS = 8'hD0,
    parameter int         NUM_DIGITS = 4,
    parameter int         SCAN_DIV   = 100000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  BUS_WE,
    input  logic [7:0]            ADDR,
    input  logic [7:0]            DATA_IN,
    output logic [7:0]            DATA_OUT,
    output logic                  DATA_OUT_VALID,
    output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]            HEX_OUT
);

    localparam int         CNT_W       = $clog2(SCAN_DIV);
    localparam int         IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CTRL_OFFSET = 8'(NUM_DIGITS);
    // Digit register keeps blank, dp and value; bits 6:5 always stored as zero.
    localparam logic [7:0] DIGIT_MASK  = 8'h9F;

    logic [7:0]       digit_reg [NUM_DIGITS];
    logic             ctrl_enable;
    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] scan_idx;

    logic [7:0]       offset;
    logic             in_range;
    logic [7:0]       read_value;
    logic [5:0]       cur_digit;   // {blank, dp, value[3:0]} of the scanned digit
    logic [7:0]       pin_hex;

    // Segment pattern for a hex nibble, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // The window is base..base+NUM_DIGITS; the lower-bound test stops wrapped offsets aliasing in.
    assign offset   = ADDR - IO_ADDRESS;
    assign in_range = (ADDR >= IO_ADDRESS) && (offset <= CTRL_OFFSET);

    // Readback mux over digit registers and the control register.
    always_comb begin
        read_value = 8'h00;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (offset == 8'(k)) begin
                read_value = digit_reg[k];
            end
        end
        if (offset == CTRL_OFFSET) begin
            read_value = {7'b0, ctrl_enable};
        end
    end

    // Select the digit currently being scanned and decode it for the cathodes.
    always_comb begin
        cur_digit = 6'h00;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_digit = {digit_reg[k][7], digit_reg[k][4:0]};
            end
        end
        if (!ctrl_enable || cur_digit[5]) begin
            pin_hex = 8'hFF;
        end else begin
            pin_hex = {~cur_digit[4], seg7(cur_digit[3:0])};
        end
    end

    // Register file writes; clear-all wipes every digit on the same edge enable updates.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_reg[k] <= 8'h00;
            end
            ctrl_enable <= 1'b1;
        end else if (BUS_WE && in_range) begin
            if (offset == CTRL_OFFSET) begin
                ctrl_enable <= DATA_IN[0];
                if (DATA_IN[1]) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        digit_reg[k] <= 8'h00;
                    end
                end
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (offset == 8'(k)) begin
                        digit_reg[k] <= DATA_IN & DIGIT_MASK;
                    end
                end
            end
        end
    end

    // Registered read port: data only for in-range read cycles, zero otherwise.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_OUT       <= 8'h00;
            DATA_OUT_VALID <= 1'b0;
        end else if (!BUS_WE && in_range) begin
            DATA_OUT       <= read_value;
            DATA_OUT_VALID <= 1'b1;
        end else begin
            DATA_OUT       <= 8'h00;
            DATA_OUT_VALID <= 1'b0;
        end
    end

    // Free-running slot timer and digit index; keeps running while the display is disabled.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Registered pin drive from the current index and register contents.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SEG_SELECT_OUT <= '1;
            HEX_OUT        <= 8'hFF;
        end else begin
            SEG_SELECT_OUT <= ctrl_enable ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
            HEX_OUT        <= pin_hex;
        end
    end

endmodule

// File: tb/tb_bus_seven_seg_scan_ctrl.sv
// tb/tb_bus_seven_seg_scan_ctrl.sv - table-driven check of bus_seven_seg_scan_ctrl
module tb_bus_seven_seg_scan_ctrl;

    logic       CLK;
    logic       RESET;
    logic       BUS_WE;
    logic [7:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OUT_VALID;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] HEX_OUT;

    logic [7:0] data_out1;
    logic       data_out_valid1;
    logic [0:0] seg_select_out1;
    logic [7:0] hex_out1;

    int checks;
    int failures;

    bus_seven_seg_scan_ctrl #(
        .IO_ADDRESS(8'hD0),
        .NUM_DIGITS(4),
        .SCAN_DIV  (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_WE        (BUS_WE),
        .ADDR          (ADDR),
        .DATA_IN       (DATA_IN),
        .DATA_OUT      (DATA_OUT),
        .DATA_OUT_VALID(DATA_OUT_VALID),
        .SEG_SELECT_OUT(SEG_SELECT_OUT),
        .HEX_OUT       (HEX_OUT)
    );

    // Single-digit instance, bus parked out of range.
    bus_seven_seg_scan_ctrl #(
        .IO_ADDRESS(8'hD0),
        .NUM_DIGITS(1),
        .SCAN_DIV  (2)
    ) dut1 (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_WE        (1'b0),
        .ADDR          (8'h00),
        .DATA_IN       (8'h00),
        .DATA_OUT      (data_out1),
        .DATA_OUT_VALID(data_out_valid1),
        .SEG_SELECT_OUT(seg_select_out1),
        .HEX_OUT       (hex_out1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
        logic [3:0] seg;
        logic [7:0] hex;
        logic [7:0] dout;
        logic       valid;
    } vec_t;

    vec_t vecs [34];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] addr, input logic [7:0] din);
        BUS_WE  = we;
        ADDR    = addr;
        DATA_IN = din;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b0;
        drive(1'b0, 8'h00, 8'h00);

        //               we    addr   din    seg   hex    dout   valid
        vecs[0]  = '{1'b1, 8'hD0, 8'h03, 4'hE, 8'hC0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'hD1, 8'h11, 4'hE, 8'hB0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'hD0, 8'h00, 4'hE, 8'hB0, 8'h03, 1'b1};
        vecs[3]  = '{1'b0, 8'hD1, 8'h00, 4'hE, 8'hB0, 8'h11, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 4'hD, 8'h79, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 8'hD2, 8'h8A, 4'hD, 8'h79, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 8'hD2, 8'h00, 4'hD, 8'h79, 8'h8A, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 4'hD, 8'h79, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 4'hB, 8'hFF, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 8'hD2, 8'h07, 4'hB, 8'hFF, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 4'hB, 8'hF8, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 8'hD5, 8'hFF, 4'hB, 8'hF8, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 8'hCF, 8'hFF, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 8'hD5, 8'h00, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 8'hD4, 8'h00, 4'h7, 8'hC0, 8'h01, 1'b1};
        vecs[15] = '{1'b1, 8'hD3, 8'h9F, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[16] = '{1'b0, 8'hD3, 8'h00, 4'hE, 8'hB0, 8'h9F, 1'b1};
        vecs[17] = '{1'b1, 8'hD3, 8'h6E, 4'hE, 8'hB0, 8'h00, 1'b0};
        vecs[18] = '{1'b0, 8'hD3, 8'h00, 4'hE, 8'hB0, 8'h0E, 1'b1};
        vecs[19] = '{1'b1, 8'hD4, 8'h03, 4'hE, 8'hB0, 8'h00, 1'b0};
        vecs[20] = '{1'b0, 8'hD4, 8'h00, 4'hD, 8'hC0, 8'h01, 1'b1};
        vecs[21] = '{1'b0, 8'hD2, 8'h00, 4'hD, 8'hC0, 8'h00, 1'b1};
        vecs[22] = '{1'b1, 8'hD4, 8'h00, 4'hD, 8'hC0, 8'h00, 1'b0};
        vecs[23] = '{1'b0, 8'h00, 8'h00, 4'hF, 8'hFF, 8'h00, 1'b0};
        vecs[24] = '{1'b0, 8'h00, 8'h00, 4'hF, 8'hFF, 8'h00, 1'b0};
        vecs[25] = '{1'b1, 8'hD2, 8'h04, 4'hF, 8'hFF, 8'h00, 1'b0};
        vecs[26] = '{1'b1, 8'hD4, 8'h01, 4'hF, 8'hFF, 8'h00, 1'b0};
        vecs[27] = '{1'b0, 8'h00, 8'h00, 4'hB, 8'h99, 8'h00, 1'b0};
        vecs[28] = '{1'b0, 8'h00, 8'h00, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[29] = '{1'b1, 8'hD0, 8'h1E, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[30] = '{1'b0, 8'h00, 8'h00, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[31] = '{1'b0, 8'h00, 8'h00, 4'h7, 8'hC0, 8'h00, 1'b0};
        vecs[32] = '{1'b0, 8'h00, 8'h00, 4'hE, 8'h06, 8'h00, 1'b0};
        vecs[33] = '{1'b0, 8'hD0, 8'h00, 4'hE, 8'h06, 8'h1E, 1'b1};

        // Held in reset across a clock edge.
        #8;
        check("reset_seg",   {4'h0, SEG_SELECT_OUT}, 8'h0F);
        check("reset_hex",   HEX_OUT, 8'hFF);
        check("reset_dout",  DATA_OUT, 8'h00);
        check("reset_valid", {7'b0, DATA_OUT_VALID}, 8'h00);
        check("reset_seg1",  {7'b0, seg_select_out1}, 8'h01);
        check("reset_hex1",  hex_out1, 8'hFF);

        #4;
        RESET = 1'b1;
        for (int i = 0; i < 34; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].din);
            @(posedge CLK);
            #1;
            check($sformatf("row%0d_seg", i),   {4'h0, SEG_SELECT_OUT}, {4'h0, vecs[i].seg});
            check($sformatf("row%0d_hex", i),   HEX_OUT, vecs[i].hex);
            check($sformatf("row%0d_dout", i),  DATA_OUT, vecs[i].dout);
            check($sformatf("row%0d_valid", i), {7'b0, DATA_OUT_VALID}, {7'b0, vecs[i].valid});
            check($sformatf("row%0d_seg1", i),  {7'b0, seg_select_out1}, 8'h00);
            check($sformatf("row%0d_hex1", i),  hex_out1, 8'hC0);
        end

        // Mid-scan asynchronous reset: outputs drop to reset values with no edge.
        drive(1'b0, 8'hD0, 8'h00);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        check("async_seg",   {4'h0, SEG_SELECT_OUT}, 8'h0F);
        check("async_hex",   HEX_OUT, 8'hFF);
        check("async_dout",  DATA_OUT, 8'h00);
        check("async_valid", {7'b0, DATA_OUT_VALID}, 8'h00);
        check("async_seg1",  {7'b0, seg_select_out1}, 8'h01);

        // Release and confirm registers came back to reset values.
        drive(1'b0, 8'h00, 8'h00);
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        drive(1'b0, 8'hD0, 8'h00);
        @(posedge CLK);
        #1;
        check("post_d0_dout",  DATA_OUT, 8'h00);
        check("post_d0_valid", {7'b0, DATA_OUT_VALID}, 8'h01);
        check("post_seg",      {4'h0, SEG_SELECT_OUT}, 8'h0E);
        check("post_hex",      HEX_OUT, 8'hC0);
        drive(1'b0, 8'hD4, 8'h00);
        @(posedge CLK);
        #1;
        check("post_ctrl_dout",  DATA_OUT, 8'h01);
        check("post_ctrl_valid", {7'b0, DATA_OUT_VALID}, 8'h01);
        drive(1'b0, 8'h00, 8'h00);
        @(posedge CLK);
        #1;
        check("post_idle_valid", {7'b0, DATA_OUT_VALID}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
